// File: rtl/max6675_scheduler.sv
// max6675_scheduler: read sequencer for the max6675_reader SPI shifter.
// Issues periodic or one-shot reads, enforces the MAX6675 conversion gap,
// decodes frames and exposes results, a threshold alarm and an IRQ on the
// PicoSoC iomem bus (32-byte window at BASE_ADDR).
// Build option: define MAX6675_SCHED_AVG_EN to add a 12-bit IIR average
// (AVG register, alarm compares the average instead of the raw sample).
module max6675_scheduler #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          CONV_MS   = 250,
  parameter int          TMO_CYC   = 100_000,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_rdata,
  output logic        rd_start,
  input  logic        rd_busy,
  input  logic        rd_ready,
  input  logic [15:0] rd_data,
  output logic        irq
);

  // state | meaning
  // IDLE  | waiting for enable or a pending one-shot
  // START | one-cycle rd_start pulse to the reader
  // WAIT  | frame in flight, timeout down-counter running
  // GAP   | conversion gap after CS rises (also the power-up state)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CONV_CYC = (CLK_HZ / 1000) * CONV_MS;
  localparam int GAP_W    = $clog2(CONV_CYC + 1);
  localparam int TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CONV_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic        enable, pending, valid, open_tc, alarm, err;
  logic [11:0] temp, thresh, cmp_val;
  logic [15:0] sample_cnt;
  logic [31:0] rd_mux;

  logic       acc, wr, ctrl_wr, thresh_wr;
  logic [2:0] reg_sel;
  logic       oneshot_set, alarm_clr, err_clr;
  logic       start_go, frame_ok, frame_good, timeout;
  logic [11:0] temp_new;
  logic       unused_bits;

  // Bus decode; the !iomem_ready term keeps a held request from being
  // accepted twice while the master sees the acknowledge.
  assign acc       = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]) && !iomem_ready;
  assign wr        = acc && (iomem_wstrb != 4'b0000);
  assign reg_sel   = iomem_addr[4:2];
  assign ctrl_wr   = wr && (reg_sel == 3'd0) && iomem_wstrb[0];
  assign thresh_wr = wr && (reg_sel == 3'd3);

  assign oneshot_set = ctrl_wr && iomem_wdata[1];
  assign alarm_clr   = ctrl_wr && iomem_wdata[2];
  assign err_clr     = ctrl_wr && iomem_wdata[3];

  assign start_go   = (state == S_IDLE) && (enable || pending) && !rd_busy;
  assign frame_ok   = (state == S_WAIT) && rd_ready;
  assign timeout    = (state == S_WAIT) && !rd_ready && (tmo_cnt == '0);
  assign temp_new   = rd_data[14:3];
  assign frame_good = !rd_data[2];

  assign rd_start = (state == S_START);
  assign irq      = alarm;

  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:12], iomem_wstrb[3:2],
                         rd_data[15], rd_data[1:0]};

  // Sequencer. The gap counter counts up from zero so that the reset value
  // of zero already enforces a full conversion time after power-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_GAP;
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_go) state <= S_START;
        end
        S_START: begin
          tmo_cnt <= TMO_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_ready || tmo_cnt == '0) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + GAP_W'(1);
        end
      endcase
    end
  end

  // Control and threshold registers; a one-shot written in the same cycle
  // the sequencer launches a read is absorbed by that read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable  <= 1'b0;
      pending <= 1'b0;
      thresh  <= 12'hFFF;
    end else begin
      if (ctrl_wr) enable <= iomem_wdata[0];
      if (start_go)         pending <= 1'b0;
      else if (oneshot_set) pending <= 1'b1;
      if (thresh_wr && iomem_wstrb[0]) thresh[7:0]  <= iomem_wdata[7:0];
      if (thresh_wr && iomem_wstrb[1]) thresh[11:8] <= iomem_wdata[11:8];
    end
  end

`ifdef MAX6675_SCHED_AVG_EN
  logic [11:0]        avg, avg_next;
  logic signed [12:0] avg_diff, avg_step, avg_sum;
  logic               unused_avg;

  // IIR step in 13-bit signed arithmetic; the arithmetic shift floors.
  always_comb begin
    avg_diff = $signed({1'b0, temp_new}) - $signed({1'b0, avg});
    avg_step = avg_diff >>> 2;
    avg_sum  = $signed({1'b0, avg}) + avg_step;
    avg_next = valid ? avg_sum[11:0] : temp_new;
  end

  assign unused_avg = avg_sum[12];
  assign cmp_val    = avg_next;

  // Average register; the first good sample (valid still 0) seeds it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      avg <= 12'h000;
    else if (frame_ok && frame_good)  avg <= avg_next;
  end
`else
  assign cmp_val = temp_new;
`endif

  // Frame results and sticky flags; a set beats a W1 clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid      <= 1'b0;
      open_tc    <= 1'b0;
      temp       <= 12'h000;
      sample_cnt <= 16'h0000;
      alarm      <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (frame_ok) begin
        sample_cnt <= sample_cnt + 16'd1;
        if (frame_good) begin
          temp    <= temp_new;
          valid   <= 1'b1;
          open_tc <= 1'b0;
        end else begin
          open_tc <= 1'b1;
        end
      end
      if (frame_ok && frame_good && (cmp_val >= thresh)) alarm <= 1'b1;
      else if (alarm_clr)                                alarm <= 1'b0;
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Read mux.
  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      3'd0: rd_mux = {30'h0, pending, enable};
      3'd1: rd_mux = {27'h0, err, alarm, open_tc, valid, state != S_IDLE};
      3'd2: rd_mux = {20'h0, temp};
      3'd3: rd_mux = {20'h0, thresh};
      3'd4: rd_mux = {16'h0, sample_cnt};
`ifdef MAX6675_SCHED_AVG_EN
      3'd5: rd_mux = {20'h0, avg};
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  // Registered bus response: one-cycle acknowledge, zero data when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
    end else begin
      iomem_ready <= acc;
      iomem_rdata <= acc ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_max6675_scheduler.sv
// Bench for max6675_scheduler: table of frames with a scoreboard queue,
// a reader model, and hand sequences for the multi-cycle corner cases.
module tb_max6675_scheduler;
  localparam int          CONV_CYC = 1000;
  localparam int          TMO      = 300;
  localparam logic [31:0] BASE     = 32'h0300_0100;
`ifdef MAX6675_SCHED_AVG_EN
  localparam logic [31:0] V6_ST = 32'h02;
`else
  localparam logic [31:0] V6_ST = 32'h0A;
`endif

  logic        clk, resetn;
  logic        iomem_valid, iomem_ready;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic [3:0]  iomem_wstrb;
  logic        rd_start, rd_busy, rd_ready;
  logic [15:0] rd_data;
  logic        irq;

  max6675_scheduler #(.CLK_HZ(4000), .CONV_MS(250), .TMO_CYC(TMO), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
    .rd_start(rd_start), .rd_busy(rd_busy), .rd_ready(rd_ready), .rd_data(rd_data),
    .irq(irq)
  );

  typedef struct {
    logic [15:0] frame;
    logic [11:0] thresh;
    bit          clr_alarm;
    logic [31:0] exp_temp;
    logic [31:0] exp_status;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, ref_cyc = 0, n_frames = 0, n_starts = 0;
  bit mute = 0, clr_with_ready = 0;
  logic [15:0] model_frame = 16'h0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = resetn ? cyc + 1 : 0;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reader model: answers rd_start with a frame after 20 cycles unless muted,
  // and checks every start honours the conversion gap.
  initial begin
    rd_busy = 0; rd_ready = 0; rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (resetn && rd_start) begin
        n_starts++;
        n_cmp++;
        if (cyc - ref_cyc < CONV_CYC) begin
          n_fail++;
          $display("FAIL start_gap: spacing %0d cycles, required >= %0d", cyc - ref_cyc, CONV_CYC);
        end
        if (!mute) begin
          rd_busy = 1;
          repeat (20) @(negedge clk);
          rd_data  = model_frame;
          rd_ready = 1;
          if (clr_with_ready) begin
            iomem_valid = 1; iomem_addr = BASE; iomem_wdata = 32'h4; iomem_wstrb = 4'b0001;
          end
          @(negedge clk);
          rd_ready = 0;
          rd_busy  = 0;
          if (clr_with_ready) begin
            iomem_valid = 0; iomem_wstrb = 4'b0000; clr_with_ready = 0;
          end
          ref_cyc = cyc;
          n_frames++;
        end
      end
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata);
    bit got = 0;
    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = addr; iomem_wdata = wdata; iomem_wstrb = wstrb;
    rdata = 32'h0;
    @(posedge clk); #1;
    if (iomem_ready) begin got = 1; rdata = iomem_rdata; end
    iomem_valid = 0; iomem_wstrb = 4'b0000;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL bus_ready: got 0, expected 1 at addr 0x%0h", addr);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] tmp;
    bus(BASE + off, d, 4'b0011, tmp);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    bus(BASE + off, 32'h0, 4'b0000, d);
  endtask

  task automatic wait_frame(input int nf0, input string nm);
    int k = 0;
    while (n_frames == nf0 && k < 3000) begin @(posedge clk); k++; end
    if (n_frames == nf0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no frame within 3000 cycles", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] s;
    int k = 0;
    rd(32'h4, s);
    while (s[0] && k < 1500) begin rd(32'h4, s); k++; end
    if (s[0]) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: still busy, expected idle", nm);
    end
  endtask

  initial begin
    logic [31:0] d, c0, t0;
    int nf;
    vec_t e;
    vecs[0] = '{16'h0C80, 12'hFFF, 0, 32'h190, 32'h02, 32'd1};
    vecs[1] = '{16'h0004, 12'hFFF, 0, 32'h190, 32'h06, 32'd2};
    vecs[2] = '{16'h0C80, 12'hFFF, 0, 32'h190, 32'h02, 32'd3};
    vecs[3] = '{16'h0C80, 12'h190, 0, 32'h190, 32'h0A, 32'd4};
    vecs[4] = '{16'h0C78, 12'h190, 1, 32'h18F, 32'h02, 32'd5};
    vecs[5] = '{16'h0004, 12'h000, 0, 32'h18F, 32'h06, 32'd6};
    vecs[6] = '{16'hFFF8, 12'hFFF, 0, 32'hFFF, V6_ST,  32'd7};

    iomem_valid = 0; iomem_addr = 0; iomem_wdata = 0; iomem_wstrb = 0;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;

    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rd_start", {31'h0, rd_start}, 32'h0);
    rd(32'h0, d);  check("rst_ctrl", d, 32'h0);
    rd(32'h4, d);  check("rst_status", d, 32'h01);
    rd(32'h8, d);  check("rst_temp", d, 32'h0);
    rd(32'hC, d);  check("rst_thresh", d, 32'hFFF);
    rd(32'h10, d); check("rst_count", d, 32'h0);

    // Table: one-shot read per record, expectation queued at stimulus time.
    for (int i = 0; i < 7; i++) begin
      rd(32'hC, d);
      if (d[11:0] != vecs[i].thresh) wr(32'hC, {20'h0, vecs[i].thresh});
      if (vecs[i].clr_alarm) wr(32'h0, 32'h4);
      model_frame = vecs[i].frame;
      sb.push_back(vecs[i]);
      nf = n_frames;
      wr(32'h0, 32'h2);
      wait_frame(nf, $sformatf("v%0d_frame", i));
      wait_idle($sformatf("v%0d_idle", i));
      e = sb.pop_front();
      rd(32'h8, d);  check($sformatf("v%0d_temp", i), d, e.exp_temp);
      rd(32'h4, d);  check($sformatf("v%0d_status", i), d, e.exp_status);
      rd(32'h10, d); check($sformatf("v%0d_count", i), d, e.exp_count);
      check($sformatf("v%0d_irq", i), {31'h0, irq}, {31'h0, e.exp_status[3]});
    end

    // Alarm set and W1 clear on the same cycle: the set wins.
    wr(32'h0, 32'h4);
    #1 check("alarm_clr_irq", {31'h0, irq}, 32'h0);
    wr(32'hC, 32'h190);
    model_frame = 16'h0C80;
    clr_with_ready = 1;
    nf = n_frames;
    wr(32'h0, 32'h2);
    wait_frame(nf, "collide_frame");
    rd(32'h4, d); check("collide_status", d, 32'h0B);
    check("collide_irq", {31'h0, irq}, 32'h1);
    wr(32'h0, 32'h4);
    rd(32'h4, d); check("late_clr_status", d, 32'h03);
    check("late_clr_irq", {31'h0, irq}, 32'h0);
    wait_idle("collide_idle");

    // Bus corners: out of window, unmapped, RO write, byte strobes.
    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = BASE + 32'h20; iomem_wstrb = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("oow_ready", {31'h0, iomem_ready}, 32'h0);
      check("oow_rdata", iomem_rdata, 32'h0);
    end
    iomem_valid = 0;
    rd(32'h18, d); check("unmapped_rd", d, 32'h0);
    wr(32'h8, 32'hFFFF);
    rd(32'h8, d); check("ro_write_temp", d, 32'h190);
    bus(BASE + 32'hC, 32'h0000_0A55, 4'b0010, d);
    rd(32'hC, d); check("strobe_thresh", d, 32'hA90);
`ifndef MAX6675_SCHED_AVG_EN
    rd(32'h14, d); check("avg_off_rd", d, 32'h0);
`endif

    // Periodic reads: three frames, start spacing checked by the reader.
    wr(32'hC, 32'hFFF);
    model_frame = 16'h0C80;
    rd(32'h10, c0);
    wr(32'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      nf = n_frames;
      wait_frame(nf, "periodic_frame");
    end
    wr(32'h0, 32'h0);
    wait_idle("periodic_idle");
    rd(32'h10, d); check("periodic_count", d, c0 + 3);

    // One-shots written during the gap coalesce into one read.
    nf = n_frames;
    wr(32'h0, 32'h2);
    wait_frame(nf, "coalesce_first");
    wr(32'h0, 32'h2); wr(32'h0, 32'h2); wr(32'h0, 32'h2);
    rd(32'h0, d); check("pending_in_gap", d, 32'h2);
    nf = n_frames;
    repeat (2500) @(posedge clk);
    check("coalesce_frames", n_frames, nf + 1);
    rd(32'h0, d); check("pending_done", d, 32'h0);

    // Timeout: no rd_ready, err sets after TMO cycles and data is kept.
    mute = 1;
    rd(32'h8, t0);
    rd(32'h10, c0);
    nf = n_starts;
    wr(32'h0, 32'h2);
    begin
      int k = 0;
      while (n_starts == nf && k < 1500) begin @(posedge clk); k++; end
    end
    check("tmo_started", n_starts, nf + 1);
    repeat (TMO - 50) @(posedge clk);
    rd(32'h4, d); check("tmo_before", d, 32'h03);
    repeat (60) @(posedge clk);
    rd(32'h4, d); check("tmo_err", d, 32'h13);
    rd(32'h8, d); check("tmo_temp", d, t0);
    rd(32'h10, d); check("tmo_count", d, c0);
    wait_idle("tmo_idle");
    rd(32'h4, d); check("tmo_idle_status", d, 32'h12);
    wr(32'h0, 32'h8);
    rd(32'h4, d); check("err_clr", d, 32'h02);

    // Reset asserted mid-WAIT.
    wr(32'h0, 32'h1);
    nf = n_starts;
    begin
      int k = 0;
      while (n_starts == nf && k < 1500) begin @(posedge clk); k++; end
    end
    repeat (10) @(posedge clk);
    #2 resetn = 0;
    #1;
    check("arst_rd_start", {31'h0, rd_start}, 32'h0);
    check("arst_ready", {31'h0, iomem_ready}, 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    mute = 0;
    ref_cyc = 0;
    rd(32'h0, d);  check("arst_ctrl", d, 32'h0);
    rd(32'h4, d);  check("arst_status", d, 32'h01);
    rd(32'h8, d);  check("arst_temp", d, 32'h0);
    rd(32'hC, d);  check("arst_thresh", d, 32'hFFF);
    rd(32'h10, d); check("arst_count", d, 32'h0);

`ifdef MAX6675_SCHED_AVG_EN
    model_frame = 16'h0800;
    nf = n_frames;
    wr(32'h0, 32'h2);
    wait_frame(nf, "avg_f1");
    rd(32'h14, d); check("avg_seed", d, 32'h100);
    model_frame = 16'h0C00;
    wait_idle("avg_idle");
    nf = n_frames;
    wr(32'h0, 32'h2);
    wait_frame(nf, "avg_f2");
    rd(32'h14, d); check("avg_step", d, 32'h120);
    rd(32'h8, d);  check("avg_temp", d, 32'h180);
`else
    model_frame = 16'h0C80;
    nf = n_frames;
    wr(32'h0, 32'h2);
    wait_frame(nf, "post_rst_frame");
    rd(32'h10, d); check("post_rst_count", d, 32'd1);
    rd(32'h8, d);  check("post_rst_temp", d, 32'h190);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
